// File: rtl/md_sched_if.sv
// Handshake bundle between the EX-stage decode/hazard logic and md_sched.
// The flush signal exists only when MD_FLUSH_EN is defined.
interface md_sched_if;
    logic [2:0] md_op_E;
    logic       md_use_D;
`ifdef MD_FLUSH_EN
    logic       flush;
`endif
    logic       Start;
    logic [1:0] unit_op;
    logic       Busy;
    logic       stall_D;
    logic       commit;
    logic       mthi_we;
    logic       mtlo_we;

`ifdef MD_FLUSH_EN
    modport master (
        output md_op_E, md_use_D, flush,
        input  Start, unit_op, Busy, stall_D, commit, mthi_we, mtlo_we
    );
    modport slave (
        input  md_op_E, md_use_D, flush,
        output Start, unit_op, Busy, stall_D, commit, mthi_we, mtlo_we
    );
`else
    modport master (
        output md_op_E, md_use_D,
        input  Start, unit_op, Busy, stall_D, commit, mthi_we, mtlo_we
    );
    modport slave (
        input  md_op_E, md_use_D,
        output Start, unit_op, Busy, stall_D, commit, mthi_we, mtlo_we
    );
`endif
endinterface

// File: rtl/md_sched.sv
// Multiply/divide sequencing controller: launches the HI/LO unit, tracks its latency with a
// down-counter and drives busy/stall/commit strobes. Optional abort path: MD_FLUSH_EN.
//
// state  | meaning
// IDLE   | no op in flight; E-stage md ops launch or write HI/LO directly
// RUN    | unit busy; cnt counts remaining cycles, commit at cnt==1
module md_sched #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input logic     clk,
    input logic     reset,
    md_sched_if.slave md
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0] state;
    logic [3:0] cnt;
    logic       flush_c;
    logic       idle_ok;
    logic       is_launch;
    logic [3:0] lat_sel;

`ifdef MD_FLUSH_EN
    assign flush_c = md.flush;
`else
    assign flush_c = 1'b0;
`endif

    assign is_launch = (md.md_op_E >= 3'd1) && (md.md_op_E <= 3'd4);
    assign idle_ok   = (state == S_IDLE) && !reset && !flush_c;
    assign lat_sel   = (md.md_op_E <= 3'd2) ? 4'(MULT_LAT) : 4'(DIV_LAT);

    // op codes 1..4 map to unit_op 0..3; the 2-bit wrap of 4-1 gives 3
    assign md.Start   = idle_ok && is_launch;
    assign md.unit_op = md.Start ? (md.md_op_E[1:0] - 2'd1) : 2'd0;
    assign md.mthi_we = idle_ok && (md.md_op_E == 3'd5);
    assign md.mtlo_we = idle_ok && (md.md_op_E == 3'd6);
    assign md.Busy    = (state == S_RUN);
    assign md.commit  = (state == S_RUN) && (cnt == 4'd1) && !flush_c;
    assign md.stall_D = !reset && md.md_use_D && (md.Start || md.Busy);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (md.Start) begin
                        state <= S_RUN;
                        cnt   <= lat_sel;
                    end
                end
                S_RUN: begin
                    if (flush_c || (cnt == 4'd1)) begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: IDLE decode vector table plus hand-written
// multi-cycle sequences; expected commit cycles are queued at launch and popped on commit.
module tb_md_sched;
    localparam int ML = 5;
    localparam int DL = 10;

    logic clk;
    logic reset;
    md_sched_if ifc();

    md_sched #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic       use_d;
        logic       start;
        logic [1:0] uop;
        logic       mthi;
        logic       mtlo;
        logic       stall;
        int         lat;
    } vec_t;

    vec_t vecs[8];
    int   sb_q[$];
    int   cyc;
    int   checks;
    int   errors;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // advance one cycle and settle at the falling edge; commits are matched against the queue
    task automatic step();
        int exp_c;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (ifc.commit) begin
            if (sb_q.size() == 0) begin
                chk("commit_unexpected", 1, 0);
            end else begin
                exp_c = sb_q.pop_front();
                chk("commit_cycle", cyc, exp_c);
            end
        end else if (sb_q.size() > 0 && sb_q[0] <= cyc) begin
            exp_c = sb_q.pop_front();
            chk("commit_missing", 0, 1);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int t0;
        checks = 0;
        errors = 0;
        cyc    = 0;
        vecs[0] = '{3'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0};
        vecs[1] = '{3'd1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, ML};
        vecs[2] = '{3'd2, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, ML};
        vecs[3] = '{3'd3, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, DL};
        vecs[4] = '{3'd4, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, DL};
        vecs[5] = '{3'd5, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 0};
        vecs[6] = '{3'd6, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 0};
        vecs[7] = '{3'd7, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0};

        reset        = 1'b1;
        ifc.md_op_E  = 3'd1;
        ifc.md_use_D = 1'b1;
`ifdef MD_FLUSH_EN
        ifc.flush    = 1'b0;
`endif
        steps(2);
        #1;
        chk("rst_start", int'(ifc.Start), 0);
        chk("rst_stall", int'(ifc.stall_D), 0);
        chk("rst_unit_op", int'(ifc.unit_op), 0);
        ifc.md_op_E = 3'd5;
        #1;
        chk("rst_mthi", int'(ifc.mthi_we), 0);
        ifc.md_op_E = 3'd6;
        #1;
        chk("rst_mtlo", int'(ifc.mtlo_we), 0);
        step();
        reset       = 1'b0;
        ifc.md_op_E = 3'd0;
        #1;
        chk("rst_busy", int'(ifc.Busy), 0);
        chk("rst_commit", int'(ifc.commit), 0);
        steps(2);

        // IDLE decode table; launched ops are followed through to commit
        foreach (vecs[i]) begin
            ifc.md_op_E  = vecs[i].op;
            ifc.md_use_D = vecs[i].use_d;
            #1;
            chk($sformatf("v%0d_start", i), int'(ifc.Start), int'(vecs[i].start));
            chk($sformatf("v%0d_uop", i), int'(ifc.unit_op), int'(vecs[i].uop));
            chk($sformatf("v%0d_mthi", i), int'(ifc.mthi_we), int'(vecs[i].mthi));
            chk($sformatf("v%0d_mtlo", i), int'(ifc.mtlo_we), int'(vecs[i].mtlo));
            chk($sformatf("v%0d_stall", i), int'(ifc.stall_D), int'(vecs[i].stall));
            if (vecs[i].start) sb_q.push_back(cyc + vecs[i].lat);
            step();
            ifc.md_op_E = 3'd0;
            for (int k = 0; k < vecs[i].lat; k++) begin
                #1;
                chk($sformatf("v%0d_busy", i), int'(ifc.Busy), 1);
                chk($sformatf("v%0d_stall_run", i), int'(ifc.stall_D), int'(vecs[i].use_d));
                step();
            end
            #1;
            chk($sformatf("v%0d_idle", i), int'(ifc.Busy), 0);
            step();
        end

        // mtlo during RUN is ignored and leaves commit timing alone
        ifc.md_use_D = 1'b0;
        ifc.md_op_E  = 3'd1;
        sb_q.push_back(cyc + ML);
        step();
        ifc.md_op_E = 3'd6;
        #1;
        chk("run_mtlo", int'(ifc.mtlo_we), 0);
        chk("run_start", int'(ifc.Start), 0);
        step();
        ifc.md_op_E = 3'd0;
        steps(ML - 1);
        #1;
        chk("run_mtlo_idle", int'(ifc.Busy), 0);
        step();

        // reset in the 4th busy cycle of a div cancels its commit
        ifc.md_op_E = 3'd3;
        sb_q.push_back(cyc + DL);
        step();
        ifc.md_op_E = 3'd0;
        steps(3);
        reset = 1'b1;
        sb_q.delete();
        step();
        reset = 1'b0;
        #1;
        chk("midrst_busy", int'(ifc.Busy), 0);
        chk("midrst_commit", int'(ifc.commit), 0);
        steps(12);
        ifc.md_op_E = 3'd1;
        sb_q.push_back(cyc + ML);
        step();
        ifc.md_op_E = 3'd0;
        steps(ML);
        #1;
        chk("postrst_idle", int'(ifc.Busy), 0);
        step();

        // back-to-back: div requested in the commit cycle launches only the next cycle
        ifc.md_op_E = 3'd1;
        sb_q.push_back(cyc + ML);
        step();
        ifc.md_op_E = 3'd0;
        steps(ML - 1);
        ifc.md_op_E = 3'd3;
        #1;
        chk("b2b_commit_now", int'(ifc.commit), 1);
        chk("b2b_no_start", int'(ifc.Start), 0);
        step();
        #1;
        chk("b2b_start", int'(ifc.Start), 1);
        chk("b2b_uop", int'(ifc.unit_op), 2);
        t0 = cyc;
        sb_q.push_back(t0 + DL);
        step();
        ifc.md_op_E = 3'd0;
        for (int k = 0; k < DL; k++) begin
            #1;
            chk("b2b_busy", int'(ifc.Busy), 1);
            step();
        end
        #1;
        chk("b2b_idle", int'(ifc.Busy), 0);
        chk("b2b_span", cyc, t0 + DL + 1);
        step();

`ifdef MD_FLUSH_EN
        // flush in the 3rd busy cycle aborts the mult
        ifc.md_op_E = 3'd1;
        sb_q.push_back(cyc + ML);
        step();
        ifc.md_op_E = 3'd0;
        steps(2);
        ifc.flush = 1'b1;
        sb_q.delete();
        #1;
        chk("fl_busy", int'(ifc.Busy), 1);
        step();
        ifc.flush = 1'b0;
        #1;
        chk("fl_idle", int'(ifc.Busy), 0);
        steps(8);
        // flush on the terminal-count cycle suppresses commit
        ifc.md_op_E = 3'd2;
        sb_q.push_back(cyc + ML);
        step();
        ifc.md_op_E = 3'd0;
        steps(ML - 1);
        ifc.flush = 1'b1;
        sb_q.delete();
        #1;
        chk("fl_tc_commit", int'(ifc.commit), 0);
        step();
        ifc.flush = 1'b0;
        #1;
        chk("fl_tc_idle", int'(ifc.Busy), 0);
        // flush in IDLE blocks launches and direct writes
        ifc.flush    = 1'b1;
        ifc.md_use_D = 1'b1;
        ifc.md_op_E  = 3'd2;
        #1;
        chk("fl_no_start", int'(ifc.Start), 0);
        chk("fl_no_stall", int'(ifc.stall_D), 0);
        ifc.md_op_E = 3'd5;
        #1;
        chk("fl_no_mthi", int'(ifc.mthi_we), 0);
        step();
        ifc.flush   = 1'b0;
        ifc.md_op_E = 3'd0;
        #1;
        chk("fl_idle_after", int'(ifc.Busy), 0);
        steps(3);
`endif

        steps(3);
        chk("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
